// File: rtl/twiddle_pkg.sv
// Shared types and constant helpers for the twiddle sequencer.
// The ROM table is built at elaboration with integer-only fixed-point math.
package twiddle_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_N     = 256;
  localparam int MAX_NBITS = 16;
  localparam int ROM_W     = (MAX_N / 2) * 2 * MAX_NBITS;

  localparam longint FX_ONE = 64'sd1073741824;
  localparam longint FX_PI  = 64'sd3373259426;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic longint sat(input longint v, input int nbits);
    longint hi;
    longint lo;
    hi = (longint'(1) << (nbits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint fx_cos(input longint x);
    longint x2;
    longint term;
    longint acc;
    x2   = (x * x) >>> 30;
    term = FX_ONE;
    acc  = FX_ONE;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / (2 * k * (2 * k - 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic longint fx_sin(input longint x);
    longint x2;
    longint term;
    longint acc;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / (2 * k * (2 * k + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Full scale is 2^(NBITS-1)-1 so that +1.0 and -1.0 are symmetric.
  function automatic longint fx_round(input longint v, input int nbits);
    longint scale;
    scale = (longint'(1) << (nbits - 1)) - 1;
    if (v >= 0) return (v * scale + FX_ONE / 2) >>> 30;
    return -(((-v) * scale + FX_ONE / 2) >>> 30);
  endfunction

  function automatic logic [ROM_W-1:0] twiddle_rom_init(
    input int n,
    input int nbits
  );
    logic [ROM_W-1:0] rom;
    longint ang;
    longint cs;
    longint sn;
    longint re;
    longint im;
    rom = '0;
    for (int e = 0; e < n / 2 && e < MAX_N / 2; e++) begin
      if (4 * e <= n) ang = (2 * FX_PI * e) / n;
      else ang = (FX_PI * (n - 2 * e)) / n;
      cs = fx_cos(ang);
      sn = fx_sin(ang);
      if (4 * e > n) cs = -cs;
      re = sat(fx_round(cs, nbits), nbits);
      im = sat(fx_round(-sn, nbits), nbits);
      for (int b = 0; b < nbits; b++) begin
        rom[e * 2 * nbits + nbits + b] = re[b];
        rom[e * 2 * nbits + b]         = im[b];
      end
    end
    return rom;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational N/2-entry twiddle lookup; entry = {real, imag}.
// Contents are fixed at elaboration from twiddle_rom_init.
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter  int NBITS = 8,
  parameter  int N     = 8,
  localparam int LOGN  = clog2(N)
) (
  input  logic [LOGN-2:0]    index,
  output logic [2*NBITS-1:0] coeff
);

  localparam logic [ROM_W-1:0] TABLE =
    twiddle_rom_init(N, NBITS);

  assign coeff = TABLE[index*(2*NBITS) +: 2*NBITS];

endmodule

// File: rtl/twiddle_seq.sv
// Twiddle sequencer: streams one FFT stage of exponents and coefficients.
// Define TWIDDLE_CONJ_EN to add the inv port for conjugate (IFFT) twiddles.
module twiddle_seq
  import twiddle_pkg::*;
#(
  parameter  int NBITS = 8,
  parameter  int N     = 8,
  parameter  int LANES = 1,
  localparam int LOGN  = clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LOGN-1:0]            stage,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*NBITS*2-1:0]   coeff_out,
  output logic [LANES*(LOGN-1)-1:0]  exp_out
`ifdef TWIDDLE_CONJ_EN
  ,
  input  logic                       inv
`endif
);

  localparam int NB = N / (2 * LANES);
  localparam int W  = 2 * NBITS;

  state_t state, state_n;
  logic [LOGN-1:0] s_q, sel_s;
  logic [LOGN-1:0] beat, sel_b;
  logic [LOGN-1:0] k, mask;
  logic last_q, load, adv, err_n;
  logic [LANES*(LOGN-1)-1:0] exp_nxt;
  logic [LANES*W-1:0] rom_c, coeff_nxt;

  assign busy = (state == RUN);
  assign done = out_valid & out_ready & last_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (int'(stage) < LOGN) begin
            load    = 1'b1;
            state_n = RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_valid && out_ready) begin
          adv = 1'b1;
          if (last_q) state_n = IDLE;
        end
      end
    endcase
  end

  // Address the next beat: beat 0 of the incoming stage, or beat+1.
  always_comb begin
    sel_s   = (state == IDLE) ? stage : s_q;
    sel_b   = (state == IDLE) ? '0 : beat + 1'b1;
    mask    = LOGN'((N >> (int'(sel_s) + 1)) - 1);
    k       = '0;
    exp_nxt = '0;
    for (int l = 0; l < LANES; l++) begin
      k = LOGN'(int'(sel_b) * LANES + l);
      exp_nxt[l*(LOGN-1) +: LOGN-1] =
        (LOGN-1)'((k & mask) << sel_s);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_rom
    twiddle_rom #(
      .NBITS (NBITS),
      .N     (N)
    ) u_rom (
      .index (exp_nxt[g*(LOGN-1) +: LOGN-1]),
      .coeff (rom_c[g*W +: W])
    );
  end

`ifdef TWIDDLE_CONJ_EN
  localparam logic [NBITS-1:0] IM_MIN = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] IM_MAX = {1'b0, {(NBITS-1){1'b1}}};
  logic inv_q, inv_sel;
  logic [NBITS-1:0] im;

  assign inv_sel = (state == IDLE) ? inv : inv_q;

  always_comb begin
    coeff_nxt = rom_c;
    im        = '0;
    for (int l = 0; l < LANES; l++) begin
      im = rom_c[l*W +: NBITS];
      if (inv_sel)
        coeff_nxt[l*W +: NBITS] = (im == IM_MIN) ? IM_MAX : -im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) inv_q <= 1'b0;
    else if (load) inv_q <= inv;
  end
`else
  assign coeff_nxt = rom_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      beat      <= '0;
      last_q    <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      coeff_out <= '0;
      exp_out   <= '0;
    end else begin
      err <= err_n;
      if (load) begin
        s_q       <= stage;
        beat      <= '0;
        last_q    <= (NB == 1);
        out_valid <= 1'b1;
        coeff_out <= coeff_nxt;
        exp_out   <= exp_nxt;
      end else if (adv) begin
        if (last_q) begin
          out_valid <= 1'b0;
        end else begin
          beat      <= sel_b;
          last_q    <= (int'(sel_b) == NB - 1);
          coeff_out <= coeff_nxt;
          exp_out   <= exp_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq: one LANES=1 and one LANES=2 instance.
// Build with TWIDDLE_CONJ_EN to also cover the conjugate path.
module tb_twiddle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int total = 0;
  int bad = 0;
  int beats_a = 0;

  logic start_a, ready_a, busy_a, done_a, err_a, valid_a;
  logic [2:0] stage_a;
  logic [15:0] coeff_a;
  logic [1:0] exp_a;
  logic inv_a;

  logic start_b, ready_b, busy_b, done_b, err_b, valid_b;
  logic [2:0] stage_b;
  logic [31:0] coeff_b;
  logic [3:0] exp_b;
  logic inv_b;

  twiddle_seq #(.NBITS(8), .N(8), .LANES(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stage(stage_a),
    .busy(busy_a), .done(done_a), .err(err_a),
    .out_valid(valid_a), .out_ready(ready_a),
    .coeff_out(coeff_a), .exp_out(exp_a)
`ifdef TWIDDLE_CONJ_EN
    , .inv(inv_a)
`endif
  );

  twiddle_seq #(.NBITS(8), .N(8), .LANES(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stage(stage_b),
    .busy(busy_b), .done(done_b), .err(err_b),
    .out_valid(valid_b), .out_ready(ready_b),
    .coeff_out(coeff_b), .exp_out(exp_b)
`ifdef TWIDDLE_CONJ_EN
    , .inv(inv_b)
`endif
  );

  typedef struct {
    logic [1:0]  e;
    logic [15:0] c;
    logic        last;
  } ba_t;

  typedef struct {
    logic [3:0]  e;
    logic [31:0] c;
    logic        last;
  } bb_t;

  ba_t qa[$];
  bb_t qb[$];

  logic [15:0] romf [4] = '{16'h7F00, 16'h5AA6, 16'h0081, 16'hA6A6};
  logic [15:0] romc [4] = '{16'h7F00, 16'h5A5A, 16'h007F, 16'hA65A};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [1:0] e, input logic last,
                        input logic conj);
    ba_t t;
    t.e = e;
    t.c = conj ? romc[e] : romf[e];
    t.last = last;
    qa.push_back(t);
  endtask

  task automatic push_b(input logic [1:0] e1, input logic [1:0] e0,
                        input logic last);
    bb_t t;
    t.e = {e1, e0};
    t.c = {romf[e1], romf[e0]};
    t.last = last;
    qb.push_back(t);
  endtask

  always @(negedge clk) begin : mon_a
    ba_t t;
    if (valid_a && ready_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_extra: got exp %0d want no beat", exp_a);
      end else begin
        t = qa.pop_front();
        chk("a_exp", 32'(exp_a), 32'(t.e));
        chk("a_coeff", 32'(coeff_a), 32'(t.c));
        chk("a_done", 32'(done_a), 32'(t.last));
        beats_a++;
      end
    end else if (done_a) begin
      total++; bad++;
      $display("FAIL a_done_idle: got 1 want 0");
    end
  end

  always @(negedge clk) begin : mon_b
    bb_t t;
    if (valid_b && ready_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra: got exp %0h want no beat", exp_b);
      end else begin
        t = qb.pop_front();
        chk("b_exp", 32'(exp_b), 32'(t.e));
        chk("b_coeff", coeff_b, t.c);
        chk("b_done", 32'(done_b), 32'(t.last));
      end
    end
  end

  task automatic wait_done_a();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) return;
    end
    total++; bad++;
    $display("FAIL a_timeout: got no done want done");
  endtask

  task automatic wait_done_b();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_b) return;
    end
    total++; bad++;
    $display("FAIL b_timeout: got no done want done");
  endtask

  task automatic run_a(input logic [2:0] s, input logic iv);
    @(posedge clk); #1;
    start_a = 1'b1; stage_a = s; ready_a = 1'b1; inv_a = iv;
    @(posedge clk); #1;
    start_a = 1'b0; inv_a = 1'b0;
    @(negedge clk);
    chk("a_first_valid", 32'(valid_a), 32'd1);
    chk("a_busy", 32'(busy_a), 32'd1);
    wait_done_a();
  endtask

  task automatic run_b(input logic [2:0] s);
    @(posedge clk); #1;
    start_b = 1'b1; stage_b = s; ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    chk("b_first_valid", 32'(valid_b), 32'd1);
    wait_done_b();
  endtask

  task automatic idle_a(input string name);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_busy"}, 32'(busy_a), 32'd0);
    chk({name, "_valid"}, 32'(valid_a), 32'd0);
  endtask

  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int b0;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; stage_a = '0; ready_a = 1'b1; inv_a = 1'b0;
    start_b = 1'b0; stage_b = '0; ready_b = 1'b1; inv_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_coeff", 32'(coeff_a), 32'd0);
    chk("rst_exp", 32'(exp_a), 32'd0);
    chk("rst_b_coeff", coeff_b, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) push_a(2'(i), i == 3, 1'b0);
    run_a(3'd0, 1'b0);
    idle_a("s0_end");

    push_a(2'd0, 1'b0, 1'b0); push_a(2'd2, 1'b0, 1'b0);
    push_a(2'd0, 1'b0, 1'b0); push_a(2'd2, 1'b1, 1'b0);
    run_a(3'd1, 1'b0);
    for (int i = 0; i < 4; i++) push_a(2'd0, i == 3, 1'b0);
    run_a(3'd2, 1'b0);
    idle_a("b2b_end");

    b0 = beats_a;
    for (int i = 0; i < 4; i++) push_a(2'(i), i == 3, 1'b0);
    @(posedge clk); #1;
    start_a = 1'b1; stage_a = 3'd0;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ready_a = pat[i];
      @(negedge clk);
      if (!ready_a) begin
        chk("stall_valid", 32'(valid_a), 32'd1);
        chk("stall_exp", 32'(exp_a), 32'(qa[0].e));
        chk("stall_coeff", 32'(coeff_a), 32'(qa[0].c));
      end
      @(posedge clk); #1;
    end
    ready_a = 1'b1;
    chk("stall_beats", 32'(beats_a - b0), 32'd4);
    @(negedge clk);
    chk("stall_busy", 32'(busy_a), 32'd0);

    @(posedge clk); #1;
    start_a = 1'b1; stage_a = 3'd3;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("err_pulse", 32'(err_a), 32'd1);
    chk("err_busy", 32'(busy_a), 32'd0);
    chk("err_valid", 32'(valid_a), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_clear", 32'(err_a), 32'd0);
    chk("err_valid2", 32'(valid_a), 32'd0);

    for (int i = 0; i < 4; i++) push_a(2'(i), i == 3, 1'b0);
    @(posedge clk); #1;
    start_a = 1'b1; stage_a = 3'd0;
    @(posedge clk); #1;
    stage_a = 3'd1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a();
    idle_a("ign_end");

    push_a(2'd0, 1'b0, 1'b0); push_a(2'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    start_a = 1'b1; stage_a = 3'd0; ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready_a = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_exp", 32'(exp_a), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0; ready_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_coeff", 32'(coeff_a), 32'd0);
    chk("mid_rst_exp", 32'(exp_a), 32'd0);
    for (int i = 0; i < 4; i++) push_a(2'(i), i == 3, 1'b0);
    run_a(3'd0, 1'b0);

`ifdef TWIDDLE_CONJ_EN
    for (int i = 0; i < 4; i++) push_a(2'(i), i == 3, 1'b1);
    run_a(3'd0, 1'b1);
    for (int i = 0; i < 4; i++) push_a(2'(i), i == 3, 1'b0);
    run_a(3'd0, 1'b0);
`endif

    push_b(2'd1, 2'd0, 1'b0); push_b(2'd3, 2'd2, 1'b1);
    run_b(3'd0);
    push_b(2'd2, 2'd0, 1'b0); push_b(2'd2, 2'd0, 1'b1);
    run_b(3'd1);
    push_b(2'd0, 2'd0, 1'b0); push_b(2'd0, 2'd0, 1'b1);
    run_b(3'd2);

    @(posedge clk); #1;
    @(negedge clk);
    chk("b_end_busy", 32'(busy_b), 32'd0);
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
